// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite register file: NUM_REGS registers with byte strobes, read-only slots
// fed from hw_status, and fully independent read and write channels.
module axi4_lite_regfile #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    NUM_REGS   = 8,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_W);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[ADDR_LSB +: IDX_W];
   endfunction

   logic                  aw_full_q, aw_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                  w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0]     w_strb_q, w_strb_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];
   logic [DATA_WIDTH-1:0] hw_arr [NUM_REGS];
   logic                  wr_commit;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic                  ar_hs;

   // Every channel transfers on the rising edge where VALID and READY are both
   // high; a source holds VALID and its payload stable until that edge.
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_arready = (!rvalid_q || s_axi_rready) && !areset;
   assign wr_pulse      = wr_pulse_q;

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[i];
         hw_arr[i] = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      aw_full_d  = aw_full_q;
      aw_addr_d  = aw_addr_q;
      w_full_d   = w_full_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      rf_d       = rf_q;
      wr_commit  = aw_full_q && w_full_q && !bvalid_q;
      wr_idx     = addr_idx(aw_addr_q);

      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
      if (s_axi_awvalid && awready_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = s_axi_awaddr;
      end
      if (s_axi_wvalid && wready_q) begin
         w_full_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end
      // A commit never coincides with a new accept: ready is low while a buffer is full.
      if (wr_commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (aw_addr_q >= ADDR_LIMIT) begin
            bresp_d = RESP_DECERR;
         end else if (RO_MASK[wr_idx]) begin
            bresp_d = RESP_SLVERR;
         end else begin
            bresp_d            = RESP_OKAY;
            wr_pulse_d[wr_idx] = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
               if (w_strb_q[b]) rf_d[wr_idx][b*8 +: 8] = w_data_q[b*8 +: 8];
            end
         end
      end
      awready_d = !aw_full_d;
      wready_d  = !w_full_d;
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rd_idx   = addr_idx(s_axi_araddr);
      ar_hs    = s_axi_arvalid && s_axi_arready;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         if (s_axi_araddr >= ADDR_LIMIT) begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
         end else begin
            rdata_d = RO_MASK[rd_idx] ? hw_arr[rd_idx] : rf_q[rd_idx];
            rresp_d = RESP_OKAY;
         end
      end else if (s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_full_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_full_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= RST_VAL;
      end else begin
         aw_full_q  <= aw_full_d;
         aw_addr_q  <= aw_addr_d;
         w_full_q   <= w_full_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rf_q       <= rf_d;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Bench for axi4_lite_regfile: directed vector table, hand-written stall/reset
// sequences and randomized traffic against an array-based register model.
module tb_axi4_lite_regfile;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NR = 8;
   localparam logic [NR-1:0] RO  = 8'b0100_0100;
   localparam logic [DW-1:0] RST = '0;

   logic            aclk = 1'b0;
   logic            areset = 1'b1;
   logic [AW-1:0]   awaddr = '0;
   logic            awvalid = 1'b0;
   logic            awready;
   logic [DW-1:0]   wdata = '0;
   logic [DW/8-1:0] wstrb = '0;
   logic            wvalid = 1'b0;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready = 1'b1;
   logic [AW-1:0]   araddr = '0;
   logic            arvalid = 1'b0;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready = 1'b1;
   logic [NR*DW-1:0] reg_q;
   logic [NR*DW-1:0] hw_status;
   logic [NR-1:0]   wr_pulse;

   axi4_lite_regfile #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO), .RST_VAL(RST)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_q(reg_q), .hw_status(hw_status), .wr_pulse(wr_pulse)
   );

   // clock / reset
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] mdl [NR];
   logic [DW-1:0] exp_q [$];
   int            pulse_cnt [NR];

   always @(negedge aclk) begin
      if (!areset) begin
         for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
      end
   end

   task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model
   function automatic logic [1:0] m_wresp(input logic [AW-1:0] a);
      if (a >= NR * (DW / 8)) return 2'b11;
      return RO[int'(a / (DW / 8))] ? 2'b10 : 2'b00;
   endfunction

   function automatic void m_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
      int idx;
      if (a >= NR * (DW / 8)) begin
         d = '0;
         r = 2'b11;
      end else begin
         idx = int'(a / (DW / 8));
         d = RO[idx] ? hw_status[idx*DW +: DW] : mdl[idx];
         r = 2'b00;
      end
   endfunction

   function automatic void m_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
      int idx;
      if (m_wresp(a) == 2'b00) begin
         idx = int'(a / (DW / 8));
         for (int b = 0; b < DW / 8; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) if (!RO[i]) v[i*DW +: DW] = mdl[i];
      return v;
   endfunction

   function automatic logic [NR*DW-1:0] rw_view(input logic [NR*DW-1:0] v);
      for (int i = 0; i < NR; i++) if (RO[i]) v[i*DW +: DW] = '0;
      return v;
   endfunction

   function automatic int pulse_total();
      int s;
      s = 0;
      for (int i = 0; i < NR; i++) s += pulse_cnt[i];
      return s;
   endfunction

   // driver tasks
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] strb, input int aw_dly, input int w_dly,
                            input bit send_aw = 1'b1, input bit send_w = 1'b1);
      bit aw_done, w_done, aw_hs, w_hs;
      int cyc;
      aw_done = !send_aw;
      w_done  = !send_w;
      cyc = 0;
      while (!(aw_done && w_done) && cyc < 60) begin
         @(negedge aclk);
         awaddr  = addr;
         wdata   = data;
         wstrb   = strb;
         awvalid = !aw_done && cyc >= aw_dly;
         wvalid  = !w_done && cyc >= w_dly;
         aw_hs   = awvalid && awready;
         w_hs    = wvalid && wready;
         @(posedge aclk);
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
         cyc++;
      end
      if (!(aw_done && w_done)) check("wr_accept_timeout", 0, 1);
      @(negedge aclk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
   endtask

   task automatic collect_b(output logic [1:0] resp, output int lat);
      lat  = 0;
      resp = 2'b01;
      while (!bvalid && lat < 60) begin
         @(negedge aclk);
         lat++;
      end
      if (!bvalid) check("b_timeout", 0, 1);
      else begin
         resp = bresp;
         @(negedge aclk);
      end
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output bit on_time);
      bit hs;
      int cyc;
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 60) begin
         @(negedge aclk);
         araddr  = addr;
         arvalid = 1'b1;
         hs      = arready;
         @(posedge aclk);
         cyc++;
      end
      @(negedge aclk);
      arvalid = 1'b0;
      on_time = hs && rvalid;
      data    = rdata;
      resp    = rresp;
   endtask

   task automatic do_write_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [DW/8-1:0] strb, input int awd, input int wd,
                               input logic [1:0] exp_resp);
      int idx, p_tot, p_idx, exp_p, lat;
      logic [1:0] resp;
      idx   = (addr < NR * (DW / 8)) ? int'(addr / (DW / 8)) : 0;
      p_tot = pulse_total();
      p_idx = pulse_cnt[idx];
      exp_p = (exp_resp == 2'b00) ? 1 : 0;
      axi_write(addr, data, strb, awd, wd);
      collect_b(resp, lat);
      check({tag, "_bresp"}, resp, exp_resp);
      check({tag, "_blat"}, lat, 1);
      check({tag, "_bsingle"}, bvalid, 0);
      m_write(addr, data, strb);
      check({tag, "_regq"}, rw_view(reg_q), model_flat());
      check({tag, "_pulse_tot"}, pulse_total() - p_tot, exp_p);
      check({tag, "_pulse_idx"}, pulse_cnt[idx] - p_idx, exp_p);
   endtask

   task automatic do_read_chk(input string tag, input logic [AW-1:0] addr,
                              input logic [DW-1:0] exp_d, input logic [1:0] exp_r);
      logic [DW-1:0] d, e;
      logic [1:0]    r;
      bit            ot;
      exp_q.push_back(exp_d);
      axi_read(addr, d, r, ot);
      e = exp_q.pop_front();
      check({tag, "_rlat"}, ot, 1);
      check({tag, "_rdata"}, d, e);
      check({tag, "_rresp"}, r, exp_r);
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [$];

   initial begin
      logic [DW-1:0] e, d;
      logic [1:0]    r, r1, r2;
      int            lat, p1, cyc;
      bit            ot, stable, stale;
      logic [AW-1:0] a, b2b_addr [3];

      vecs.push_back('{1'b0, 32'h00, 32'h0,          4'h0, 0, 0, 2'b00, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h08, 32'h0,          4'h0, 0, 0, 2'b00, 32'hDEAD_BEEF});
      vecs.push_back('{1'b0, 32'h1C, 32'h0,          4'h0, 0, 0, 2'b00, 32'h0000_0000});
      vecs.push_back('{1'b1, 32'h0C, 32'hA5A5_5A5A, 4'hF, 0, 0, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h0C, 32'h0,          4'h0, 0, 0, 2'b00, 32'hA5A5_5A5A});
      vecs.push_back('{1'b1, 32'h00, 32'h1122_3344, 4'h5, 3, 0, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,          4'h0, 0, 0, 2'b00, 32'h0022_0044});
      vecs.push_back('{1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 1, 0, 2'b10, 32'h0});
      vecs.push_back('{1'b0, 32'h08, 32'h0,          4'h0, 0, 0, 2'b00, 32'hDEAD_BEEF});
      vecs.push_back('{1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 2, 2'b11, 32'h0});
      vecs.push_back('{1'b0, 32'h20, 32'h0,          4'h0, 0, 0, 2'b11, 32'h0000_0000});
      vecs.push_back('{1'b1, 32'h0E, 32'h7700_0000, 4'h8, 0, 0, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h0F, 32'h0,          4'h0, 0, 0, 2'b00, 32'h77A5_5A5A});
      vecs.push_back('{1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 0, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 32'h14, 32'h0,          4'h0, 0, 0, 2'b00, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,   4'h0, 0, 0, 2'b11, 32'h0000_0000});
      vecs.push_back('{1'b1, 32'h18, 32'h0BAD_0BAD, 4'hF, 0, 0, 2'b10, 32'h0});

      for (int i = 0; i < NR; i++) begin
         mdl[i] = RST;
         hw_status[i*DW +: DW] = $urandom;
      end
      hw_status[2*DW +: DW] = 32'hDEAD_BEEF;

      // reset state
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_ready", {awready, wready, arready}, 3'b000);
      check("rst_valid", {bvalid, rvalid}, 2'b00);
      check("rst_resp_data", {bresp, rresp, rdata}, '0);
      check("rst_pulse", wr_pulse, '0);
      check("rst_regq", rw_view(reg_q), model_flat());
      areset = 1'b0;
      @(negedge aclk);
      check("post_rst_ready", {awready, wready, arready}, 3'b111);

      // directed vector table
      foreach (vecs[i]) begin
         if (vecs[i].is_wr)
            do_write_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].aw_dly, vecs[i].w_dly, vecs[i].exp_resp);
         else
            do_read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
      end

      // B held off while a second write waits in the buffers
      bready = 1'b0;
      p1 = pulse_cnt[1];
      axi_write(32'h04, 32'h1111_1111, 4'hF, 0, 0);
      m_write(32'h04, 32'h1111_1111, 4'hF);
      axi_write(32'h04, 32'h2222_2222, 4'hF, 0, 0);
      for (int k = 0; k < 5; k++) begin
         check("bhold_state", {bvalid, bresp, awready, wready, reg_q[1*DW +: DW]},
               {1'b1, 2'b00, 1'b0, 1'b0, 32'h1111_1111});
         @(negedge aclk);
      end
      bready = 1'b1;
      collect_b(r1, lat);
      check("bhold_first_resp", r1, 2'b00);
      check("bhold_not_committed", reg_q[1*DW +: DW], 32'h1111_1111);
      collect_b(r2, lat);
      check("bhold_second_resp", r2, 2'b00);
      check("bhold_second_lat", lat, 1);
      m_write(32'h04, 32'h2222_2222, 4'hF);
      check("bhold_regq", rw_view(reg_q), model_flat());
      check("bhold_pulses", pulse_cnt[1] - p1, 2);

      // R held off: rvalid/rdata stable and arready low
      rready = 1'b0;
      @(negedge aclk);
      araddr  = 32'h04;
      arvalid = 1'b1;
      check("rhold_arready_idle", arready, 1);
      @(negedge aclk);
      arvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("rhold_state", {rvalid, rresp, arready, rdata}, {1'b1, 2'b00, 1'b0, 32'h2222_2222});
         @(negedge aclk);
      end
      rready = 1'b1;
      #1;
      check("rhold_arready_rready", arready, 1);
      @(negedge aclk);
      check("rhold_released", rvalid, 0);

      // back-to-back reads, one beat per cycle
      b2b_addr[0] = 32'h00;
      b2b_addr[1] = 32'h08;
      b2b_addr[2] = 32'h0C;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            e = exp_q.pop_front();
            check("b2b_rvalid", rvalid, 1);
            check("b2b_rdata", rdata, e);
         end
         if (k < 3) begin
            arvalid = 1'b1;
            araddr  = b2b_addr[k];
            check("b2b_arready", arready, 1);
            m_read(b2b_addr[k], e, r);
            exp_q.push_back(e);
         end else begin
            arvalid = 1'b0;
         end
         @(negedge aclk);
      end

      // randomized traffic against the model
      for (int n = 0; n < 120; n++) begin
         a = (n % 17 == 16) ? $urandom : AW'($urandom_range(0, 39));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            do_write_chk("rnd_wr", a, d, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), m_wresp(a));
         end else begin
            hw_status[6*DW +: DW] = $urandom;
            m_read(a, e, r);
            do_read_chk("rnd_rd", a, e, r);
         end
      end

      // reset with B and R pending and a lone AW buffered
      bready = 1'b0;
      rready = 1'b0;
      axi_write(32'h04, 32'h1234_5678, 4'hF, 0, 0);
      axi_read(32'h04, d, r, ot);
      axi_write(32'h10, 32'h0000_0055, 4'hF, 0, 0, 1'b1, 1'b0);
      check("prerst_valids", {bvalid, rvalid}, 2'b11);
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("midrst_valid", {bvalid, rvalid, wr_pulse}, '0);
      check("midrst_ready", {awready, wready, arready}, 3'b000);
      for (int i = 0; i < NR; i++) mdl[i] = RST;
      check("midrst_regq", rw_view(reg_q), model_flat());
      areset = 1'b0;
      bready = 1'b1;
      rready = 1'b1;
      axi_write(32'h0, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b0, 1'b1);
      stale = 1'b0;
      cyc = 0;
      repeat (6) begin
         @(negedge aclk);
         if (bvalid || rvalid) stale = 1'b1;
         cyc++;
      end
      check("rst_no_stale", stale, 0);
      check("rst_buffers", {awready, wready}, 2'b10);
      axi_write(32'h14, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0);
      collect_b(r, lat);
      check("rst_new_bresp", r, 2'b00);
      check("rst_new_blat", lat, 1);
      m_write(32'h14, 32'hCAFE_F00D, 4'hF);
      check("rst_new_regq", rw_view(reg_q), model_flat());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_lite_regfile.md
Name: axi4_lite_regfile

Overview:
Parametrised AXI4-Lite subordinate register file, the successor to the fixed 8-register subordinate. It provides NUM_REGS registers, WSTRB byte enables, and a per-register read-only mask with hardware-sourced status. It decodes errors as SLVERR or DECERR and runs the read and write channels independently with proper VALID/READY holding. It sits between the interconnect and block control/status logic.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64.
ADDR_WIDTH, 32, AXI address width.
NUM_REGS, 8, number of registers; 2..256.
RO_MASK, '0 (NUM_REGS bits), bit i=1 makes register i read-only (value from hw_status).
RST_VAL, '0 (DATA_WIDTH), reset value of every RW register.

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
reg_q  out  NUM_REGS*DATA_WIDTH  flattened RW register contents; register i at [i*DW +: DW]
hw_status  in  NUM_REGS*DATA_WIDTH  values returned for RO registers
wr_pulse  out  NUM_REGS  one-cycle strobe per committed write to register i

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state:
  - All ready, valid and resp outputs are 0; rdata is 0; wr_pulse is 0.
  - RW registers load RST_VAL.
  - Holding buffers are emptied.
  - Reset mid-transaction drops all in-flight transactions; no response is issued for them.
- Decode:
  - ADDR_LSB = log2(DATA_WIDTH/8); idx = addr >> ADDR_LSB; low ADDR_LSB address bits are ignored.
  - addr >= NUM_REGS*(DATA_WIDTH/8) gives DECERR (2'b11).
  - Write to an RO_MASK register gives SLVERR (2'b10).
  - Everything else gives OKAY (2'b00).
- Write channel:
  - AW and W are captured in independent one-entry holding buffers and may arrive in either order or in the same cycle.
  - awready = AW buffer empty; wready = W buffer empty; both are registered outputs.
  - Commit happens when both buffers are full and bvalid is 0. The register bytes with wstrb[b]=1 update on that edge. bvalid, bresp and wr_pulse[idx] assert on the same edge, and both buffers empty.
  - AW and W accepted at edge N: commit at edge N+1, bvalid is high after N+1, and awready/wready return to 1 after N+1.
  - wstrb = 0 responds OKAY with no change, and wr_pulse still fires.
  - Error writes change nothing, and wr_pulse does not fire.
  - bvalid is held with a stable bresp until bready; it clears on the handshake edge.
  - While bvalid=1 the next AW/W may be buffered but is not committed.
- Read channel:
  - arready = !rvalid | rready (combinational).
  - On an AR handshake at edge N: rdata, rresp and rvalid are registered at edge N, giving one-cycle latency.
  - RW registers return reg_q. RO registers return hw_status sampled on the handshake edge. DECERR returns rdata=0.
  - rdata and rresp stay stable while rvalid=1 and rready=0. Back-to-back reads give one beat per cycle when rready=1.
- Simultaneous events:
  - A read and a write to the same register on the same edge return the pre-write value.
  - The read and write channels never stall each other.
- reg_q reflects the committed value from the edge after commit.

Test Plan:
1. Reset, then read every register -> rdata=RST_VAL, rresp=00. Then write 0xA5A5_5A5A to reg 3 with AW and W in the same cycle -> bvalid 1 cycle later, bresp=00, wr_pulse[3] pulses once, reg_q[3]=0xA5A5_5A5A.
2. W three cycles before AW, wstrb=4'b0101, data 0x1122_3344 to reg 0 (was 0) -> reg0=0x0022_0044, with a single B beat.
3. RO_MASK[2]=1, hw_status[2]=0xDEAD_BEEF -> read gives 0xDEAD_BEEF/OKAY; write to reg 2 gives SLVERR, no wr_pulse, value unchanged.
4. NUM_REGS=8, addr 0x20 -> write gives DECERR with no register changed; read gives DECERR with rdata=0.
5. Hold bready=0 for 5 cycles after a write while issuing a second AW/W -> bvalid and bresp stay stable, the second write is not committed until the first B handshake, then two responses arrive in order. Hold rready=0 -> rvalid and rdata stay stable and arready=0.
6. Assert areset while bvalid=1 and rvalid=1 -> next cycle all valid signals are 0, registers return to RST_VAL, and no stale response appears after reset.
